equiv_sweep_ctrl: RTL and testbench
===================================

Name: equiv_sweep_ctrl

Overview:
Sequencer that exhaustively sweeps every input vector of a small combinational gate pair. The pair is a gate-level implementation (dut) and its behavioural equation (ref), for example a NAND-built XNOR against a behavioural XNOR. For each vector it drives the shared inputs, waits a settle time, compares the two outputs, and accumulates results. It replaces hand-written per-exercise stimulus blocks and gives a single pass/fail summary per gate pair.

Parameters:
N_IN, 2, number of gate inputs; the sweep covers 2^N_IN vectors (1..8 supported).
SETTLE, 1, clock cycles between driving a vector and sampling outputs; must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
start  input  1  begin a sweep; sampled in IDLE and DONE only.
abort  input  1  terminate an in-progress sweep.
vec  output  N_IN  input vector driven to both ref and dut.
ref_out  input  1  output of the behavioural model.
dut_out  input  1  output of the gate-level implementation.
busy  output  1  high in SETTLE and SAMPLE states.
done  output  1  level; high in DONE state until the next start or reset.
pass  output  1  valid while done=1; 1 if mism_count==0.
mism_count  output  N_IN+1  number of mismatching vectors in the last sweep.
first_fail_valid  output  1  a mismatch has been captured this sweep.
first_fail_vec  output  N_IN  vector of the first mismatch.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; vec=0, busy=0, done=0, pass=0, mism_count=0, first_fail_valid=0, first_fail_vec=0, settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE. Encoding is binary.
- IDLE, start=1: vec<=0; mism_count, first_fail_valid and first_fail_vec are cleared; settle counter<=0; next state SETTLE.
- SETTLE: settle counter increments each cycle. When it equals SETTLE-1, next state is SAMPLE.
- SAMPLE, mismatch = ref_out XOR dut_out:
  - If mismatch, mism_count++. No saturation is needed, since the maximum is 2^N_IN and fits N_IN+1 bits.
  - If mismatch and first_fail_valid=0: first_fail_vec<=vec and first_fail_valid<=1.
  - If vec is all-ones: next state DONE, and vec holds its value.
  - Otherwise: vec<=vec+1, settle counter<=0, next state SETTLE.
- DONE: done=1; pass is computed from the final count, including the last sample.
  - start=1 restarts exactly as from IDLE, in the same cycle clearing done and pass.
- Timing: vec changes only on entry to SETTLE, so it is stable for the full settle and sample window.
- Latency: done rises 2^N_IN*(SETTLE+1) rising edges after the edge that samples start. For N_IN=2, SETTLE=1 this is 8 edges.
- start while busy is ignored.
- abort=1 in SETTLE or SAMPLE: next state IDLE, vec<=0, done stays 0, pass stays 0. Counters keep their partial values for debug. Abort has priority over the SAMPLE update in the same cycle.
- abort in IDLE or DONE: no effect. If start and abort are both high in IDLE, start wins.
- Unknown (X) values on ref_out or dut_out are a bench error; the RTL applies plain XOR.

Decomposition:
- Shared package: state encoding localparams (S_IDLE=0, S_SETTLE=1, S_SAMPLE=2, S_DONE=3) and the default N_IN and SETTLE values, reused by all gate-exercise benches.
- One sub-module: settle_timer. It is a width-parameterised down-counter with load, and raises an expire flag after SETTLE cycles. The FSM loads it on entry to SETTLE.
- Vector counter, compare logic and first-fail capture stay in the top module.

Test Plan:
- Matched XNOR pair (dut built from NANDs, ref = ~(a^b)), N_IN=2, SETTLE=1, pulse start -> vec walks 00,01,10,11; done high 8 edges after start; pass=1, mism_count=0, first_fail_valid=0.
- dut_out tied 0 against XNOR ref -> mismatches at 00 and 11; mism_count=2, first_fail_vec=00, pass=0.
- dut_out tied 1 against XNOR ref -> mismatches at 01 and 10; mism_count=2, first_fail_vec=01.
- SETTLE=3 -> vec changes every 4 cycles; done 16 edges after start; start pulsed mid-sweep is ignored (vec sequence unchanged).
- rst asserted during vector 10 (asynchronous, mid-cycle) -> all outputs 0 immediately; after release, a new start gives a full clean sweep.
- abort in SAMPLE of vector 01 with a faulty dut -> IDLE next cycle, done=0, vec=00, mism_count retains its partial value; then start in DONE after a full sweep restarts the sweep with counters cleared.

Source files
------------

// File: rtl/equiv_sweep_ctrl_pkg.sv
// Shared definitions for the gate-pair equivalence sweep controller.
// Provides the FSM state encoding, default sweep parameters and a helper
// that sizes the settle timer.
package equiv_sweep_ctrl_pkg;

  // Sequencer states, binary encoded.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Defaults shared by the gate-exercise benches.
  localparam int unsigned N_IN_DEFAULT   = 2;
  localparam int unsigned SETTLE_DEFAULT = 1;

  // Width needed to hold SETTLE-1, never less than one bit.
  function automatic int unsigned settle_cnt_width(input int unsigned settle);
    return (settle <= 2) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/equiv_sweep_ctrl_settle_timer.sv
// Settle timer: loadable down-counter that flags expiry when it reaches zero
// while enabled. Loading SETTLE-1 makes o_expire rise in the SETTLE-th
// enabled cycle after the load.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high (counter cleared to 0)
//   i_load      load i_load_val into the counter (priority over counting)
//   i_load_val  value loaded on i_load
//   i_en        count down while high
//   o_expire    high while enabled and the counter is zero
module equiv_sweep_ctrl_settle_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_expire = i_en && (r_count == '0);

endmodule

// File: rtl/equiv_sweep_ctrl.sv
// Exhaustive equivalence sweep for a small combinational gate pair.
// Walks vec through every input vector, waits SETTLE cycles per vector, then
// compares ref_out against dut_out and accumulates a mismatch count and the
// first failing vector.
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   start             begin a sweep; honoured only in IDLE and DONE
//   abort             stop a running sweep and return to IDLE
//   vec               vector driven to both gate implementations
//   ref_out, dut_out  behavioural and gate-level outputs
//   busy              sweep in progress (SETTLE or SAMPLE)
//   done              sweep finished; held until next start or reset
//   pass              with done, no mismatches were seen
//   mism_count        mismatching vectors in the last sweep
//   first_fail_valid  a mismatch was captured this sweep
//   first_fail_vec    vector of the first mismatch
module equiv_sweep_ctrl
  import equiv_sweep_ctrl_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEFAULT,
  parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec,
  input  logic            ref_out,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mism_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam int unsigned     CNT_W       = settle_cnt_width(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  state_e          r_state;
  state_e          w_next_state;
  logic [N_IN-1:0] r_vec;
  logic [N_IN:0]   r_mism_count;
  logic            r_ffv;
  logic [N_IN-1:0] r_ffvec;

  logic w_start_sweep;
  logic w_sample_go;
  logic w_last_vec;
  logic w_mismatch;
  logic w_timer_load;
  logic w_expire;
  logic w_in_settle;
  logic w_abort_run;

  assign w_in_settle   = (r_state == S_SETTLE);
  assign w_abort_run   = abort && ((r_state == S_SETTLE) || (r_state == S_SAMPLE));
  assign w_start_sweep = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Abort wins over the sample update in the same cycle.
  assign w_sample_go   = (r_state == S_SAMPLE) && !abort;
  assign w_last_vec    = &r_vec;
  assign w_mismatch    = ref_out ^ dut_out;
  // Timer restarts on every entry to SETTLE.
  assign w_timer_load  = w_start_sweep || (w_sample_go && !w_last_vec);

  equiv_sweep_ctrl_settle_timer #(
    .WIDTH (CNT_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_timer_load),
    .i_load_val (SETTLE_LOAD),
    .i_en       (w_in_settle),
    .o_expire   (w_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_SETTLE;
      end
      S_SETTLE: begin
        if (abort)         w_next_state = S_IDLE;
        else if (w_expire) w_next_state = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)           w_next_state = S_IDLE;
        else if (w_last_vec) w_next_state = S_DONE;
        else                 w_next_state = S_SETTLE;
      end
      S_DONE: begin
        if (start) w_next_state = S_SETTLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_SETTLE, S_SAMPLE: busy = 1'b1;
      S_DONE:             done = 1'b1;
      default: ;
    endcase
    pass = done && (r_mism_count == '0);
  end

  // Vector counter, mismatch accumulation and first-fail capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec        <= '0;
      r_mism_count <= '0;
      r_ffv        <= 1'b0;
      r_ffvec      <= '0;
    end else if (w_start_sweep) begin
      r_vec        <= '0;
      r_mism_count <= '0;
      r_ffv        <= 1'b0;
      r_ffvec      <= '0;
    end else if (w_abort_run) begin
      // Counters keep partial values for debug.
      r_vec <= '0;
    end else if (w_sample_go) begin
      if (w_mismatch) begin
        r_mism_count <= r_mism_count + (N_IN + 1)'(1);
        if (!r_ffv) begin
          r_ffv   <= 1'b1;
          r_ffvec <= r_vec;
        end
      end
      if (!w_last_vec) r_vec <= r_vec + N_IN'(1);
    end
  end

  assign vec              = r_vec;
  assign mism_count       = r_mism_count;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Self-checking bench for equiv_sweep_ctrl: a NAND-built XNOR against a
// behavioural XNOR, with selectable fault injection on the gate-level side.
module tb_equiv_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, abort0, start1, abort1;
  logic [1:0] vec0, vec1;
  logic       ref0, dut0, ref1, dut1;
  logic       busy0, done0, pass0, ffv0;
  logic       busy1, done1, pass1, ffv1;
  logic [2:0] mism0, mism1;
  logic [1:0] ffvec0, ffvec1;

  int         checks   = 0;
  int         failures = 0;
  int         mode0    = 0;   // 0 good, 1 tied 0, 2 tied 1, 3 masked fault
  logic [3:0] mask0    = '0;

  function automatic logic nand_xnor(input logic a, input logic b);
    logic n1, n2, n3, x;
    n1 = ~(a & b);
    n2 = ~(a & n1);
    n3 = ~(b & n1);
    x  = ~(n2 & n3);
    return ~(x & x);
  endfunction

  assign ref0 = ~(vec0[1] ^ vec0[0]);
  assign ref1 = ~(vec1[1] ^ vec1[0]);
  assign dut1 = nand_xnor(vec1[1], vec1[0]);

  always_comb begin
    case (mode0)
      1:       dut0 = 1'b0;
      2:       dut0 = 1'b1;
      3:       dut0 = nand_xnor(vec0[1], vec0[0]) ^ mask0[vec0];
      default: dut0 = nand_xnor(vec0[1], vec0[0]);
    endcase
  end

  equiv_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u0 (
    .clk (clk), .rst (rst), .start (start0), .abort (abort0), .vec (vec0),
    .ref_out (ref0), .dut_out (dut0), .busy (busy0), .done (done0), .pass (pass0),
    .mism_count (mism0), .first_fail_valid (ffv0), .first_fail_vec (ffvec0)
  );

  equiv_sweep_ctrl #(.N_IN(2), .SETTLE(3)) u1 (
    .clk (clk), .rst (rst), .start (start1), .abort (abort1), .vec (vec1),
    .ref_out (ref1), .dut_out (dut1), .busy (busy1), .done (done1), .pass (pass1),
    .mism_count (mism1), .first_fail_valid (ffv1), .first_fail_vec (ffvec1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full sweep on u0; expectations come from the truth-table model below.
  task automatic sweep0(input string tag, input int mode, input logic [3:0] mask);
    int   exp_cnt = 0;
    int   first   = -1;
    int   edges   = 0;
    logic trace_ok = 1'b1;
    for (int v = 0; v < 4; v++) begin
      logic refv, dutv;
      refv = (v[1] == v[0]);
      case (mode)
        1:       dutv = 1'b0;
        2:       dutv = 1'b1;
        3:       dutv = refv ^ mask[v];
        default: dutv = refv;
      endcase
      if (dutv != refv) begin
        exp_cnt++;
        if (first < 0) first = v;
      end
    end
    mode0  = mode;
    mask0  = mask;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if ({30'd0, vec0} !== k / 2) trace_ok = 1'b0;
      if (busy0 !== 1'b1) trace_ok = 1'b0;
      tick();
      edges = k + 1;
      if (done0 === 1'b1) break;
    end
    check({tag, "_trace"}, 32'(trace_ok), 32'd1);
    check({tag, "_latency"}, edges, 32'd8);
    check({tag, "_mism"}, 32'(mism0), exp_cnt);
    check({tag, "_pass"}, 32'(pass0), 32'(exp_cnt == 0));
    check({tag, "_ffv"}, 32'(ffv0), 32'(first >= 0));
    check({tag, "_ffvec"}, 32'(ffvec0), (first >= 0) ? first : 0);
  endtask

  initial begin
    int   edges;
    logic trace_ok;

    rst    = 1'b1;
    start0 = 1'b0;
    abort0 = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;
    #12;
    check("reset_u0", {21'd0, vec0, busy0, done0, pass0, mism0, ffv0, ffvec0}, 32'd0);
    check("reset_u1", {21'd0, vec1, busy1, done1, pass1, mism1, ffv1, ffvec1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Abort in IDLE does nothing; start beats abort in IDLE.
    abort0 = 1'b1;
    tick();
    check("abort_idle_busy", 32'(busy0), 32'd0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("start_beats_abort", 32'(busy0), 32'd1);
    tick();
    abort0 = 1'b0;
    check("abort_running", {30'd0, busy0, done0}, 32'd0);

    sweep0("match", 0, 4'h0);
    sweep0("tie0", 1, 4'h0);
    sweep0("tie1", 2, 4'h0);
    for (int i = 0; i < 4; i++) sweep0("rand", 3, 4'($urandom));

    // Asynchronous reset while vector 10 is settling.
    mode0  = 0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    check("pre_rst_vec", 32'(vec0), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", {21'd0, vec0, busy0, done0, pass0, mism0, ffv0, ffvec0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    sweep0("post_rst", 0, 4'h0);

    // Abort in SAMPLE of vector 01 with every vector faulty.
    mode0  = 3;
    mask0  = 4'hf;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (3) tick();
    check("abort_pre_vec", {30'd0, vec0}, 32'd1);
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    check("abort_state", {29'd0, busy0, done0, pass0}, 32'd0);
    check("abort_vec", 32'(vec0), 32'd0);
    check("abort_mism_kept", 32'(mism0), 32'd1);
    check("abort_ffv_kept", {29'd0, ffv0, ffvec0}, 32'h4);

    sweep0("full_fault", 3, 4'hf);

    // Restart from DONE clears done and the counters.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("restart_clear", {24'd0, done0, pass0, mism0, ffv0, busy0, 1'b0}, 32'h2);
    check("restart_vec", 32'(vec0), 32'd0);
    edges = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      edges = k + 1;
      if (done0 === 1'b1) break;
    end
    check("restart_latency", edges, 32'd8);
    check("restart_mism", 32'(mism0), 32'd4);

    // SETTLE=3: vec steps every 4 cycles; a start mid-sweep is ignored.
    trace_ok = 1'b1;
    edges    = 0;
    start1   = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 128; k++) begin
      if ({30'd0, vec1} !== k / 4) trace_ok = 1'b0;
      start1 = (k == 5);
      tick();
      edges = k + 1;
      if (done1 === 1'b1) break;
    end
    start1 = 1'b0;
    check("s3_trace", 32'(trace_ok), 32'd1);
    check("s3_latency", edges, 32'd16);
    check("s3_result", {27'd0, pass1, mism1, ffv1}, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
